// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-3 stream demultiplexer.
// Optional feature macro: DEMUX_SEL_ERR_EN (drop i_sel = 3 and report it).
package demux_pkg;

  localparam int NUM_OUTPUTS = 3;

  typedef enum logic [1:0] {
    SEL_OUT0    = 2'd0,
    SEL_OUT1    = 2'd1,
    SEL_OUT2    = 2'd2,
    SEL_INVALID = 2'd3
  } sel_e;

  // Map a select code onto a one-hot slot vector; all-zero means "no slot".
  function automatic logic [NUM_OUTPUTS-1:0] sel_to_onehot(input logic [1:0] sel);
    logic [NUM_OUTPUTS-1:0] hot;
    hot = 3'b001;
    case (sel)
      SEL_OUT0:    hot = 3'b001;
      SEL_OUT1:    hot = 3'b010;
      SEL_OUT2:    hot = 3'b100;
`ifdef DEMUX_SEL_ERR_EN
      SEL_INVALID: hot = 3'b000;
`else
      SEL_INVALID: hot = 3'b001;
`endif
      default:     hot = 3'b001;
    endcase
    return hot;
  endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry valid/ready register slice. Accepts a new payload whenever it
// is empty or is being drained in the same cycle, so a continuously ready
// consumer sees one transfer per cycle.
module stream_slot #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  full;
  logic [DATA_WIDTH-1:0] payload;
  logic                  load;

  assign in_ready  = !full || out_ready;
  assign load      = in_valid && in_ready;
  assign out_valid = full;
  assign out_data  = payload;

  // A load wins over a drain so a simultaneous drain+load keeps the slot full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 1'b0;
      payload <= '0;
    end else if (load) begin
      full    <= 1'b1;
      payload <= in_data;
    end else if (out_ready) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to3_stream.sv
// 1-to-3 valid/ready stream demultiplexer with one registered slot per
// output. Each output drains independently, so a stalled consumer only
// blocks inputs addressed to it.
// Optional feature macro: DEMUX_SEL_ERR_EN -- when defined, i_sel = 3 is
// accepted and dropped with a one-cycle o_sel_err pulse; otherwise it is
// routed to output 0.
module demux1to3_stream
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [1:0]            i_sel,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid_0,
  output logic                  o_valid_1,
  output logic                  o_valid_2,
  output logic [DATA_WIDTH-1:0] o_data_0,
  output logic [DATA_WIDTH-1:0] o_data_1,
  output logic [DATA_WIDTH-1:0] o_data_2,
  input  logic                  i_ready_0,
  input  logic                  i_ready_1,
  input  logic                  i_ready_2,
  output logic                  o_sel_err
);

  logic [NUM_OUTPUTS-1:0] target;
  logic [NUM_OUTPUTS-1:0] slot_in_valid;
  logic [NUM_OUTPUTS-1:0] slot_in_ready;
  logic [NUM_OUTPUTS-1:0] slot_out_valid;
  logic [NUM_OUTPUTS-1:0] slot_out_ready;
  logic [DATA_WIDTH-1:0]  slot_out_data [NUM_OUTPUTS];

  assign target         = sel_to_onehot(i_sel);
  assign slot_in_valid  = target & {NUM_OUTPUTS{i_valid}};
  assign slot_out_ready = {i_ready_2, i_ready_1, i_ready_0};

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_slot
    stream_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk       (i_clk),
      .rst       (i_arst),
      .in_valid  (slot_in_valid[k]),
      .in_ready  (slot_in_ready[k]),
      .in_data   (i_data),
      .out_valid (slot_out_valid[k]),
      .out_ready (slot_out_ready[k]),
      .out_data  (slot_out_data[k])
    );
  end

  assign o_valid_0 = slot_out_valid[0];
  assign o_valid_1 = slot_out_valid[1];
  assign o_valid_2 = slot_out_valid[2];
  assign o_data_0  = slot_out_data[0];
  assign o_data_1  = slot_out_data[1];
  assign o_data_2  = slot_out_data[2];

  // Ready follows the addressed slot only; a dropped select is always taken
  always_comb begin
    o_ready = |(target & slot_in_ready);
`ifdef DEMUX_SEL_ERR_EN
    if (target == '0) begin
      o_ready = 1'b1;
    end
`endif
  end

`ifdef DEMUX_SEL_ERR_EN
  logic sel_err_q;

  // Pulse the error flag in the cycle after an invalid select is dropped
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= i_valid && (i_sel == SEL_INVALID);
    end
  end

  assign o_sel_err = sel_err_q;
`else
  assign o_sel_err = 1'b0;
`endif

endmodule
